conv2d_core: RTL and testbench
==============================

// Module: conv2d_core
// PURPOSE
//  Sequential 2-D convolution engine: one multiply-accumulate (MAC) per clock.
//  Captures a flattened multi-channel feature map on a start pulse, convolves it with
//  weights in internal memory `kernels`, presents a flattened output map, pulses done.
//  Sits between the board input-vector ROM and the 7-seg display mux in the Basys top.
// PARAMETERS
//  IN_CHANNELS 1 input feature channels
//  OUT_CHANNELS 1 output feature channels (filters)
//  KERN_H / KERN_W 3 / 3 kernel height / width
//  STRIDE_H / STRIDE_W 1 / 1 vertical / horizontal stride
//  PAD_H / PAD_W 0 / 0 zero padding each side, rows / cols
//  IN_H / IN_W 4 / 4 input map height / width
//  DATA_SIZE 8 element width, signed two's complement
//  derived: OUT_H=(IN_H+2*PAD_H-KERN_H)/STRIDE_H+1, OUT_W likewise; MACS=IN_CHANNELS*KERN_H*KERN_W
// PORTS
//  clk        in  1  system clock, all logic on posedge
//  reset      in  1  synchronous, active-high
//  start      in  1  1-cycle request; sampled only in IDLE
//  in_data    in  IN_CHANNELS*IN_H*IN_W*DATA_SIZE  input map
//  kern_we    in  1  weight write enable
//  kern_addr  in  clog2(OUT_CHANNELS*MACS)  weight index
//  kern_wdata in  DATA_SIZE  weight value
//  busy       out 1  high from accepted start until done
//  done       out 1  1-cycle pulse, out_data valid
//  out_data   out OUT_CHANNELS*OUT_H*OUT_W*DATA_SIZE  output map
// BEHAVIOUR
//  Packing: in element (c,r,x) at bit ((c*IN_H+r)*IN_W+x)*DATA_SIZE, LSB-first; out (o,r,x) same.
//  kernels[((o*IN_CHANNELS+c)*KERN_H+kr)*KERN_W+kc]; unpacked reg array named `kernels`,
//   loadable by $readmemh hierarchically or kern_we write (any state, takes effect next use).
//   Weights NOT cleared by reset; use during busy = undefined result.
//  Reset: state IDLE, busy=0, done=0, out_data=0, accumulator/indices 0; aborts run, no done.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 -> latch in_data, clear acc, indices 0, busy=1, go RUN.
//   RUN: per cycle add in(c,r*STRIDE_H+kr-PAD_H,x*STRIDE_W+kc-PAD_W)*w to acc;
//    out-of-bounds (padding) taps add 0 but still cost one cycle.
//    Tap order: kc fastest, then kr, then c; elements order x, r, o.
//    Last tap of element: write sat(acc+product) to out slot, clear acc.
//    Last tap of last element -> DONE.
//   DONE: done=1 exactly one cycle, busy=0 next edge, -> IDLE.
//  Latency: done high in cycle after edge OUT_CHANNELS*OUT_H*OUT_W*MACS following the start
//   edge (defaults: 4 elements x 9 taps = 36).
//  Arithmetic: signed products 2*DATA_SIZE bits; acc width 2*DATA_SIZE+clog2(MACS)+1, no overflow;
//   result saturates to [-2^(DATA_SIZE-1), 2^(DATA_SIZE-1)-1] (defaults -128..127).
//  out_data holds last result until next write; slots update progressively during RUN.
//  start while busy or in DONE: ignored (not queued). in_data changes after start: no effect.
//  start and reset same cycle: reset wins.
// STRUCTURE
//  Package conv2d_pkg: out_dim(in,pad,k,stride) function, sat(acc) function, acc width const.
//  Sub-module conv_mac: signed multiply, accumulate, clear, saturate; core = FSM + address gen.
// TESTING
//  Identity kernel (center 1, rest 0), input 0..15 row-major -> out 5,6,9,10; done at cycle 36.
//  All-ones kernel, all inputs 1 -> out 9,9,9,9; busy high 36 cycles, done single pulse.
//  All-ones kernel, inputs 100 -> 127 each; inputs -100 -> -128 each (saturation).
//  Reset asserted at cycle 10 of run -> busy=0, out_data=0, no done; fresh start completes normally.
//  Second start pulse during run -> ignored, exactly one done, results unchanged.
//  PAD=1, IN 2x2 all 1, all-ones 3x3 kernel -> OUT 2x2 = 4,4,4,4 (padding taps zero).

Source files
------------

// File: rtl/conv2d_pkg.sv
`default_nettype none
// ============================================================================
// conv2d_pkg : shared types and helpers for the conv2d_core MAC engine
// Revision   : 1.0
// ============================================================================
package conv2d_pkg;

  localparam int SAT_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int out_dim(input int in_dim, input int pad, input int k, input int stride);
    return (in_dim + 2 * pad - k) / stride + 1;
  endfunction

  // Product width plus headroom for MACS additions plus one guard bit.
  function automatic int acc_width(input int data_size, input int macs);
    return 2 * data_size + $clog2(macs) + 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] acc,
                                                  input int data_size);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (data_size - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (acc > hi)      return hi;
    else if (acc < lo) return lo;
    else               return acc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac.sv
`default_nettype none
// ============================================================================
// conv_mac : signed multiply-accumulate with clear and saturated result
// Revision : 1.0
// ============================================================================
module conv_mac
  import conv2d_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ACC_W     = 21
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        valid,
  input  logic                        last,
  input  logic signed [DATA_SIZE-1:0] a,
  input  logic signed [DATA_SIZE-1:0] b,
  output logic signed [DATA_SIZE-1:0] result
);

  logic signed [2*DATA_SIZE-1:0] prod;
  logic signed [ACC_W-1:0]       sum;
  logic signed [ACC_W-1:0]       acc_d;
  logic signed [ACC_W-1:0]       acc_q;

  // result reflects the running sum including the current tap, so the
  // core can store it on the last tap without an extra cycle.
  always_comb begin
    prod   = (2*DATA_SIZE)'(a) * (2*DATA_SIZE)'(b);
    sum    = acc_q + ACC_W'(prod);
    result = DATA_SIZE'(sat(SAT_W'(sum), DATA_SIZE));
    acc_d  = acc_q;
    if (clear)      acc_d = '0;
    else if (valid) acc_d = last ? '0 : sum;
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule
`default_nettype wire

// File: rtl/conv2d_core.sv
`default_nettype none
// ============================================================================
// conv2d_core : sequential 2-D convolution, one MAC per clock
// Revision    : 1.0
// ============================================================================
module conv2d_core
  import conv2d_pkg::*;
#(
  parameter int IN_CHANNELS  = 1,
  parameter int OUT_CHANNELS = 1,
  parameter int KERN_H       = 3,
  parameter int KERN_W       = 3,
  parameter int STRIDE_H     = 1,
  parameter int STRIDE_W     = 1,
  parameter int PAD_H        = 0,
  parameter int PAD_W        = 0,
  parameter int IN_H         = 4,
  parameter int IN_W         = 4,
  parameter int DATA_SIZE    = 8,
  localparam int OUT_H     = out_dim(IN_H, PAD_H, KERN_H, STRIDE_H),
  localparam int OUT_W     = out_dim(IN_W, PAD_W, KERN_W, STRIDE_W),
  localparam int MACS      = IN_CHANNELS * KERN_H * KERN_W,
  localparam int KERN_N    = OUT_CHANNELS * MACS,
  localparam int KA_W      = (KERN_N > 1) ? $clog2(KERN_N) : 1,
  localparam int IN_N      = IN_CHANNELS * IN_H * IN_W,
  localparam int OUT_N     = OUT_CHANNELS * OUT_H * OUT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [IN_N*DATA_SIZE-1:0]     in_data,
  input  logic                          kern_we,
  input  logic [KA_W-1:0]               kern_addr,
  input  logic [DATA_SIZE-1:0]          kern_wdata,
  output logic                          busy,
  output logic                          done,
  output logic [OUT_N*DATA_SIZE-1:0]    out_data
);

  localparam int IN_IDX_W  = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam int OUT_IDX_W = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam int ACC_W     = acc_width(DATA_SIZE, MACS);

  logic signed [DATA_SIZE-1:0] kernels [KERN_N];

  state_t                    state_q, state_d;
  logic [IN_N*DATA_SIZE-1:0] in_q, in_d;
  logic [DATA_SIZE-1:0]      out_q [OUT_N];
  logic [DATA_SIZE-1:0]      out_d [OUT_N];
  int                        kc_q, kr_q, c_q, x_q, r_q, o_q;
  int                        kc_d, kr_d, c_d, x_d, r_d, o_d;

  logic signed [DATA_SIZE-1:0] in_elem [IN_N];
  int                          row, col;
  logic                        in_bounds;
  logic [IN_IDX_W-1:0]         in_idx;
  logic [KA_W-1:0]             k_idx;
  logic [OUT_IDX_W-1:0]        out_idx;
  logic signed [DATA_SIZE-1:0] tap_a, tap_b, mac_result;
  logic                        mac_clear, mac_valid;
  logic                        tap_last, elem_last;

  always_ff @(posedge clk) begin
    if (kern_we && (int'(kern_addr) < KERN_N)) kernels[kern_addr] <= kern_wdata;
  end

  for (genvar i = 0; i < IN_N; i++) begin : g_unpack
    assign in_elem[i] = in_q[i*DATA_SIZE +: DATA_SIZE];
  end

  for (genvar i = 0; i < OUT_N; i++) begin : g_pack
    assign out_data[i*DATA_SIZE +: DATA_SIZE] = out_q[i];
  end

  // Padding taps read zero but still occupy a cycle, keeping latency fixed.
  always_comb begin
    row       = r_q * STRIDE_H + kr_q - PAD_H;
    col       = x_q * STRIDE_W + kc_q - PAD_W;
    in_bounds = (row >= 0) && (row < IN_H) && (col >= 0) && (col < IN_W);
    in_idx    = in_bounds ? IN_IDX_W'((c_q * IN_H + row) * IN_W + col) : '0;
    k_idx     = KA_W'(((o_q * IN_CHANNELS + c_q) * KERN_H + kr_q) * KERN_W + kc_q);
    out_idx   = OUT_IDX_W'((o_q * OUT_H + r_q) * OUT_W + x_q);
    tap_a     = in_bounds ? in_elem[in_idx] : '0;
    tap_b     = kernels[k_idx];
    tap_last  = (kc_q == KERN_W - 1) && (kr_q == KERN_H - 1) && (c_q == IN_CHANNELS - 1);
    elem_last = (x_q == OUT_W - 1) && (r_q == OUT_H - 1) && (o_q == OUT_CHANNELS - 1);
  end

  conv_mac #(
    .DATA_SIZE (DATA_SIZE),
    .ACC_W     (ACC_W)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (mac_clear),
    .valid  (mac_valid),
    .last   (tap_last),
    .a      (tap_a),
    .b      (tap_b),
    .result (mac_result)
  );

  always_comb begin
    state_d   = state_q;
    in_d      = in_q;
    out_d     = out_q;
    kc_d      = kc_q;
    kr_d      = kr_q;
    c_d       = c_q;
    x_d       = x_q;
    r_d       = r_q;
    o_d       = o_q;
    mac_clear = 1'b0;
    mac_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          in_d      = in_data;
          mac_clear = 1'b1;
          kc_d = 0; kr_d = 0; c_d = 0; x_d = 0; r_d = 0; o_d = 0;
        end
      end
      ST_RUN: begin
        mac_valid = 1'b1;
        if (kc_q != KERN_W - 1) kc_d = kc_q + 1;
        else begin
          kc_d = 0;
          if (kr_q != KERN_H - 1) kr_d = kr_q + 1;
          else begin
            kr_d = 0;
            c_d  = (c_q == IN_CHANNELS - 1) ? 0 : c_q + 1;
          end
        end
        if (tap_last) begin
          out_d[out_idx] = mac_result;
          if (elem_last) state_d = ST_DONE;
          if (x_q != OUT_W - 1) x_d = x_q + 1;
          else begin
            x_d = 0;
            if (r_q != OUT_H - 1) r_d = r_q + 1;
            else begin
              r_d = 0;
              o_d = (o_q == OUT_CHANNELS - 1) ? 0 : o_q + 1;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      in_q    <= '0;
      for (int i = 0; i < OUT_N; i++) out_q[i] <= '0;
      kc_q <= 0; kr_q <= 0; c_q <= 0; x_q <= 0; r_q <= 0; o_q <= 0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      out_q   <= out_d;
      kc_q <= kc_d; kr_q <= kr_d; c_q <= c_d; x_q <= x_d; r_q <= r_d; o_q <= o_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_conv2d_core.sv
`default_nettype none
// ============================================================================
// tb_conv2d_core : directed self-checking bench for conv2d_core
// Revision       : 1.0
// ============================================================================
module tb_conv2d_core;

  localparam int MAX_CYC = 200;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] in_data;
  logic         kern_we;
  logic [3:0]   kern_addr;
  logic [7:0]   kern_wdata;
  logic         busy, done;
  logic [31:0]  out_data;

  logic         p_start;
  logic [31:0]  p_in_data;
  logic         p_kern_we;
  logic [3:0]   p_kern_addr;
  logic [7:0]   p_kern_wdata;
  logic         p_busy, p_done;
  logic [31:0]  p_out_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  conv2d_core dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .kern_we    (kern_we),
    .kern_addr  (kern_addr),
    .kern_wdata (kern_wdata),
    .busy       (busy),
    .done       (done),
    .out_data   (out_data)
  );

  conv2d_core #(.PAD_H(1), .PAD_W(1), .IN_H(2), .IN_W(2)) dut_pad (
    .clk        (clk),
    .reset      (reset),
    .start      (p_start),
    .in_data    (p_in_data),
    .kern_we    (p_kern_we),
    .kern_addr  (p_kern_addr),
    .kern_wdata (p_kern_wdata),
    .busy       (p_busy),
    .done       (p_done),
    .out_data   (p_out_data)
  );

  task automatic load_main(input logic [71:0] w);
    for (int i = 0; i < 9; i++) begin
      kern_we = 1'b1; kern_addr = 4'(i); kern_wdata = w[i*8 +: 8];
      @(negedge clk);
    end
    kern_we = 1'b0;
  endtask

  task automatic run_main(input logic [127:0] din, input int restart_at, input logic [127:0] din2,
                          output logic [31:0] dout, output int lat, output int busy_n,
                          output int done_n);
    bit seen;
    seen = 1'b0; lat = -1; dout = '0; busy_n = 0; done_n = 0;
    in_data = din; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= MAX_CYC; cyc++) begin
      if (cyc == restart_at) begin in_data = din2; start = 1'b1; end
      else start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (!seen) begin seen = 1'b1; lat = cyc - 1; dout = out_data; end
      end
      if (seen && cyc >= lat + 8) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; kern_we = 1'b0; kern_addr = '0; kern_wdata = '0; in_data = '0;
    p_start = 1'b0; p_kern_we = 1'b0; p_kern_addr = '0; p_kern_wdata = '0; p_in_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++;
    if (out_data !== 32'h0) begin n_errors++; $display("FAIL reset_out got=%h exp=0", out_data); end
  endtask

  task automatic test_identity;
    logic [127:0] din; logic [31:0] dout; int lat, bn, dn;
    for (int i = 0; i < 16; i++) din[i*8 +: 8] = 8'(i);
    load_main(72'h00_0000_0001_0000_0000);
    run_main(din, -1, '0, dout, lat, bn, dn);
    n_checks++;
    if (dout !== 32'h0A09_0605) begin n_errors++; $display("FAIL ident_out got=%h exp=0a090605", dout); end
    n_checks++; if (lat !== 36) begin n_errors++; $display("FAIL ident_latency got=%0d exp=36", lat); end
    n_checks++; if (bn !== 36) begin n_errors++; $display("FAIL ident_busy got=%0d exp=36", bn); end
    n_checks++; if (dn !== 1) begin n_errors++; $display("FAIL ident_done_pulses got=%0d exp=1", dn); end
  endtask

  task automatic test_ones;
    logic [31:0] dout; int lat, bn, dn;
    load_main({9{8'h01}});
    run_main({16{8'h01}}, -1, '0, dout, lat, bn, dn);
    n_checks++;
    if (dout !== 32'h0909_0909) begin n_errors++; $display("FAIL ones_out got=%h exp=09090909", dout); end
    n_checks++; if (lat !== 36) begin n_errors++; $display("FAIL ones_latency got=%0d exp=36", lat); end
    n_checks++; if (bn !== 36) begin n_errors++; $display("FAIL ones_busy got=%0d exp=36", bn); end
    n_checks++; if (dn !== 1) begin n_errors++; $display("FAIL ones_done_pulses got=%0d exp=1", dn); end
  endtask

  task automatic test_saturation;
    logic [31:0] dout; int lat, bn, dn;
    run_main({16{8'h64}}, -1, '0, dout, lat, bn, dn);
    n_checks++;
    if (dout !== 32'h7F7F_7F7F) begin n_errors++; $display("FAIL sat_pos got=%h exp=7f7f7f7f", dout); end
    run_main({16{8'h9C}}, -1, '0, dout, lat, bn, dn);
    n_checks++;
    if (dout !== 32'h8080_8080) begin n_errors++; $display("FAIL sat_neg got=%h exp=80808080", dout); end
  endtask

  task automatic test_reset_mid_run;
    int dn; logic [31:0] dout; int lat, bn;
    dn = 0;
    in_data = {16{8'h01}}; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    n_checks++;
    if (out_data !== 32'h0) begin n_errors++; $display("FAIL midreset_out got=%h exp=0", out_data); end
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done) dn++;
      @(negedge clk);
    end
    n_checks++; if (dn !== 0) begin n_errors++; $display("FAIL midreset_no_done got=%0d exp=0", dn); end
    run_main({16{8'h01}}, -1, '0, dout, lat, bn, dn);
    n_checks++;
    if (dout !== 32'h0909_0909) begin n_errors++; $display("FAIL fresh_out got=%h exp=09090909", dout); end
    n_checks++; if (lat !== 36) begin n_errors++; $display("FAIL fresh_latency got=%0d exp=36", lat); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] dout; int lat, bn, dn;
    run_main({16{8'h01}}, 5, {16{8'h64}}, dout, lat, bn, dn);
    n_checks++;
    if (dout !== 32'h0909_0909) begin n_errors++; $display("FAIL restart_out got=%h exp=09090909", dout); end
    n_checks++; if (dn !== 1) begin n_errors++; $display("FAIL restart_done_pulses got=%0d exp=1", dn); end
    n_checks++; if (lat !== 36) begin n_errors++; $display("FAIL restart_latency got=%0d exp=36", lat); end
  endtask

  task automatic test_padding;
    bit seen; int lat; logic [31:0] dout;
    seen = 1'b0; lat = -1; dout = '0;
    for (int i = 0; i < 9; i++) begin
      p_kern_we = 1'b1; p_kern_addr = 4'(i); p_kern_wdata = 8'h01;
      @(negedge clk);
    end
    p_kern_we = 1'b0;
    p_in_data = {4{8'h01}}; p_start = 1'b1;
    @(negedge clk);
    p_start = 1'b0;
    for (int cyc = 1; cyc <= MAX_CYC && !seen; cyc++) begin
      if (p_done) begin seen = 1'b1; lat = cyc - 1; dout = p_out_data; end
      else @(negedge clk);
    end
    n_checks++;
    if (dout !== 32'h0404_0404) begin n_errors++; $display("FAIL pad_out got=%h exp=04040404", dout); end
    n_checks++; if (lat !== 36) begin n_errors++; $display("FAIL pad_latency got=%0d exp=36", lat); end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_ones();
    test_saturation();
    test_reset_mid_run();
    test_back_to_back();
    test_padding();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
